// File: rtl/decrypt_128.sv
// Iterative AES-128 inverse cipher: the key schedule is combinational from Key and
// one inverse round is applied per clock to a single 128-bit state register.
module decrypt_128 #(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [0:127] Message,
    input  logic [0:127] Key,
    output logic [0:127] decipher
);

    localparam int NW = 4 * (NR + 1);
    localparam int RKW = 128 * (NR + 1);

    // Step-counter milestones: load phase, initial key add, middle rounds, last round, done.
    localparam logic [4:0] I_LOAD_LAST = 5'(NR);
    localparam logic [4:0] I_ADD_KEY   = 5'(NR + 1);
    localparam logic [4:0] I_ROUND_END = 5'(2 * NR);
    localparam logic [4:0] I_LAST      = 5'(2 * NR + 1);
    localparam logic [4:0] I_DONE      = 5'(2 * NR + 2);

    localparam logic [0:79] RCON = 80'h01020408102040801b36;

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:2047] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // All NR+1 round keys packed back to back; round key r sits at bits 128r..128r+127.
    function automatic logic [0:RKW-1] key_expand(input logic [0:127] key);
        logic [31:0]    w [0:NW-1];
        logic [31:0]    t;
        logic [0:RKW-1] rks;
        for (int j = 0; j < NK; j++) begin
            w[j] = key[32*j +: 32];
        end
        for (int j = NK; j < NW; j++) begin
            t = w[j-1];
            if ((j % NK) == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {RCON[8*(j/NK-1) +: 8], 24'h000000};
            end
            w[j] = w[j-NK] ^ t;
        end
        for (int j = 0; j < NW; j++) begin
            rks[32*j +: 32] = w[j];
        end
        return rks;
    endfunction

    function automatic logic [0:127] add_round_key(input logic [0:127] s, input logic [0:127] rk);
        return s ^ rk;
    endfunction

    // Byte 4c+r holds row r, column c; row r rotates right by r columns.
    function automatic logic [0:127] inv_shift_rows(input logic [0:127] s);
        logic [0:127] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(4*c+r) +: 8] = s[8*(4*((c - r + 4) % 4) + r) +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [0:127] inv_sub_bytes(input logic [0:127] s);
        logic [0:127] o;
        for (int k = 0; k < 16; k++) begin
            o[8*k +: 8] = inv_sbox(s[8*k +: 8]);
        end
        return o;
    endfunction

    function automatic logic [0:127] inv_mix_columns(input logic [0:127] s);
        logic [0:127] o;
        logic [7:0]   a  [0:3];
        logic [7:0]   m9 [0:3];
        logic [7:0]   mb [0:3];
        logic [7:0]   md [0:3];
        logic [7:0]   me [0:3];
        logic [7:0]   x2, x4, x8;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a[r]  = s[8*(4*c+r) +: 8];
                x2    = xtime(a[r]);
                x4    = xtime(x2);
                x8    = xtime(x4);
                m9[r] = x8 ^ a[r];
                mb[r] = x8 ^ x2 ^ a[r];
                md[r] = x8 ^ x4 ^ a[r];
                me[r] = x8 ^ x4 ^ x2;
            end
            o[8*(4*c+0) +: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
            o[8*(4*c+1) +: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
            o[8*(4*c+2) +: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
            o[8*(4*c+3) +: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
        end
        return o;
    endfunction

    function automatic logic [0:127] inv_round(input logic [0:127] s, input logic [0:127] rk);
        return inv_mix_columns(add_round_key(inv_sub_bytes(inv_shift_rows(s)), rk));
    endfunction

    function automatic logic [0:127] inv_last_round(input logic [0:127] s, input logic [0:127] rk);
        return add_round_key(inv_sub_bytes(inv_shift_rows(s)), rk);
    endfunction

    logic [0:RKW-1] rk_all;
    logic [3:0]     rk_idx;
    logic [0:127]   rk_sel;
    logic [0:127]   state_q, state_d;
    logic [4:0]     i_q, i_d;

    assign rk_all = key_expand(Key);

    // Middle rounds walk the schedule downward from rk[NR-1] to rk[1].
    assign rk_idx = 4'(5'(2 * NR + 1) - i_q);
    assign rk_sel = rk_all[{rk_idx, 7'b0000000} +: 128];

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        if (i_q <= I_LOAD_LAST) begin
            state_d = Message;
            i_d     = i_q + 5'd1;
        end else if (i_q == I_ADD_KEY) begin
            state_d = add_round_key(Message, rk_all[128*NR +: 128]);
            i_d     = i_q + 5'd1;
        end else if (i_q <= I_ROUND_END) begin
            state_d = inv_round(state_q, rk_sel);
            i_d     = i_q + 5'd1;
        end else if (i_q == I_LAST) begin
            state_d = inv_last_round(state_q, rk_all[0 +: 128]);
            i_d     = I_DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            i_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
        end
    end

    assign decipher = state_q;

endmodule

// File: tb/tb_decrypt_128.sv
// Directed FIPS-197 vectors for decrypt_128: latency, intermediate state,
// asynchronous reset (idle and mid-run), input changes before and after completion.
module tb_decrypt_128;

  logic         clk;
  logic         rst_n;
  logic [0:127] msg;
  logic [0:127] key;
  logic [0:127] decipher;

  int n_checks;
  int n_errors;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_ARK = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  decrypt_128 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Message  (msg),
    .Key      (key),
    .decipher (decipher)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard check
  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges; output must clear at once.
  task automatic pulse_reset(input string tag);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq(tag, decipher, 128'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b1;
    key      = C1_KEY;
    msg      = C1_CT;
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("reset_state", decipher, 128'h0);
    tick(2);
    check_eq("reset_held", decipher, 128'h0);
    rst_n = 1'b1;

    // C.1 vector with intermediate checkpoints
    tick(1);
    check_eq("c1_edge1_load", decipher, C1_CT);
    tick(10);
    check_eq("c1_edge11_load", decipher, C1_CT);
    tick(1);
    check_eq("c1_edge12_ark10", decipher, C1_ARK);
    tick(10);
    check_eq("c1_edge22_plain", decipher, C1_PT);
    tick(10);
    check_eq("c1_hold_10", decipher, C1_PT);
    msg = B_CT;
    key = B_KEY;
    tick(5);
    check_eq("c1_input_change_after_done", decipher, C1_PT);

    // FIPS-197 B vector; a wrong Message before the load window closes is absorbed
    pulse_reset("async_reset_after_done");
    msg = 128'hdeadbeef_00000000_12345678_ffffffff;
    key = B_KEY;
    tick(6);
    msg = B_CT;
    tick(5);
    check_eq("b_edge11_load", decipher, B_CT);
    tick(11);
    check_eq("b_edge22_plain", decipher, B_PT);

    // Reset in the middle of the inverse rounds, then a full clean run
    pulse_reset("async_reset_idle");
    msg = C1_CT;
    key = C1_KEY;
    tick(15);
    pulse_reset("async_reset_mid_run");
    tick(21);
    check_eq("c1_edge21_not_done", (decipher == C1_PT) ? 128'h1 : 128'h0, 128'h0);
    tick(1);
    check_eq("c1_after_midrun_reset", decipher, C1_PT);

    // All-zero key and plaintext
    pulse_reset("async_reset_zero");
    msg = Z_CT;
    key = 128'h0;
    tick(22);
    check_eq("zero_vector_plain", decipher, 128'h0);
    msg = C1_CT;
    tick(3);
    check_eq("zero_input_change_after_done", decipher, 128'h0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
